// File: rtl/c3lib_cfgcsr_pulse_xfer_arb.sv
`default_nettype none
// ============================================================================
// Module   : c3lib_cfgcsr_pulse_xfer_arb
// Brief    : Round-robin sequencer sharing one slow-to-fast pulse crossing.
// Revision : 1.0 - initial release
// ============================================================================
module c3lib_cfgcsr_pulse_xfer_arb #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_xfer_ack,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_err,
    output logic               o_xfer_pulse,
    output logic [ID_W-1:0]    o_xfer_id,
    output logic               o_busy,
    output logic [7:0]         o_err_cnt
);

    localparam int C_MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int C_MAX_CNT = (TIMEOUT_CYCLES > C_MAX_PG) ? TIMEOUT_CYCLES : C_MAX_PG;
    localparam int C_CNT_W   = $clog2(C_MAX_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [C_CNT_W-1:0]   cnt;
    logic [C_CNT_W-1:0]   cnt_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      ptr_nxt;
    logic                 ack_lat;
    logic                 ack_lat_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [NUM_REQ-1:0]   done_nxt;
    logic [NUM_REQ-1:0]   err_nxt;
    logic                 pulse_nxt;
    logic [ID_W-1:0]      id_nxt;
    logic                 busy_nxt;
    logic [7:0]           err_cnt_nxt;

    logic                 found;
    logic [ID_W-1:0]      pick;
    logic [ID_W:0]        cand;

    // Rotating priority search: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && i_req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ptr_nxt     = ptr;
        ack_lat_nxt = ack_lat;
        gnt_nxt     = o_gnt;
        done_nxt    = '0;
        err_nxt     = '0;
        pulse_nxt   = o_xfer_pulse;
        id_nxt      = o_xfer_id;
        err_cnt_nxt = o_err_cnt;

        case (state)
            ST_IDLE: begin
                ack_lat_nxt = 1'b0;
                if (found) begin
                    state_nxt = ST_PULSE;
                    gnt_nxt   = NUM_REQ'(1) << pick;
                    id_nxt    = pick;
                    pulse_nxt = 1'b1;
                    cnt_nxt   = C_CNT_W'(PULSE_CYCLES - 1);
                    ptr_nxt   = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
                end
            end
            ST_PULSE: begin
                // An early ack must not be lost; it is consumed in WAIT.
                if (i_xfer_ack) begin
                    ack_lat_nxt = 1'b1;
                end
                if (cnt == '0) begin
                    state_nxt = ST_WAIT;
                    pulse_nxt = 1'b0;
                    cnt_nxt   = C_CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - C_CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (i_xfer_ack || ack_lat) begin
                    done_nxt    = o_gnt;
                    gnt_nxt     = '0;
                    ack_lat_nxt = 1'b0;
                    state_nxt   = ST_GAP;
                    cnt_nxt     = C_CNT_W'(GAP_CYCLES - 1);
                end else if (cnt == '0) begin
                    err_nxt     = o_gnt;
                    gnt_nxt     = '0;
                    err_cnt_nxt = (o_err_cnt == 8'hFF) ? o_err_cnt : o_err_cnt + 8'd1;
                    state_nxt   = ST_GAP;
                    cnt_nxt     = C_CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - C_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - C_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= '0;
            ack_lat      <= 1'b0;
            o_gnt        <= '0;
            o_done       <= '0;
            o_err        <= '0;
            o_xfer_pulse <= 1'b0;
            o_xfer_id    <= '0;
            o_busy       <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ptr          <= ptr_nxt;
            ack_lat      <= ack_lat_nxt;
            o_gnt        <= gnt_nxt;
            o_done       <= done_nxt;
            o_err        <= err_nxt;
            o_xfer_pulse <= pulse_nxt;
            o_xfer_id    <= id_nxt;
            o_busy       <= busy_nxt;
            o_err_cnt    <= err_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
